// File: rtl/gate_ctrl_n.sv
// Gate control: per-queue schedulability judge plus optional token-bucket shaper.
// Define GC_TOKEN_SHAPER_EN to compile in the token bucket on queue SHAPE_Q.
module gate_ctrl_n #(
  parameter int QUEUE_NUM  = 4,
  parameter int PORT_NUM   = 2,
  parameter int PSEL_W     = 1,
  parameter int USEDW_W    = 8,
  parameter int USEDW_TH   = 20,
  parameter int SHAPE_Q    = 2,
  parameter int TB_SIZE    = 2047,
  parameter int REFILL_CYC = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [QUEUE_NUM*PSEL_W-1:0]   in_gc_md_outport,
  input  logic [QUEUE_NUM-1:0]          in_gc_fifo_empty,
  input  logic [QUEUE_NUM-1:0]          in_gc_gate_state,
  input  logic [10:0]                   in_gc_pkt_len,
  input  logic [31:0]                   in_gc_rate_limit,
  input  logic                          in_gc_pkt_valid,
  input  logic [PORT_NUM*USEDW_W-1:0]   pktout_usedw,
  input  logic [QUEUE_NUM-1:0]          in_gc_rden,
  output logic [QUEUE_NUM-1:0]          out_gc_schedule_valid,
  output logic                          out_gc_bandwidth_discard
);

  typedef enum logic {IDLE = 1'b0, JUDGE = 1'b1} state_t;

  state_t               state, state_n;
  logic [QUEUE_NUM-1:0] sched, sched_n;
  logic                 init_flag, init_n;
  logic [QUEUE_NUM-1:0] elig;
  logic [PSEL_W-1:0]    op;
  logic                 hit;
  logic                 lvl_ok;

  // A queue is eligible only if its head packet targets a real port with room.
  always_comb begin
    elig   = '0;
    op     = '0;
    hit    = 1'b0;
    lvl_ok = 1'b0;
    for (int q = 0; q < QUEUE_NUM; q++) begin
      op     = in_gc_md_outport[q*PSEL_W +: PSEL_W];
      hit    = 1'b0;
      lvl_ok = 1'b0;
      for (int p = 0; p < PORT_NUM; p++) begin
        if (32'(op) == 32'(p)) begin
          hit    = 1'b1;
          lvl_ok = (32'(pktout_usedw[p*USEDW_W +: USEDW_W]) <= 32'(USEDW_TH));
        end
      end
      elig[q] = in_gc_gate_state[q] & ~in_gc_fifo_empty[q] & hit & lvl_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sched     <= '0;
      init_flag <= 1'b1;
    end else begin
      state     <= state_n;
      sched     <= sched_n;
      init_flag <= init_n;
    end
  end

  // A nonzero result is shown for one cycle, then the FSM waits for the next packet-done.
  always_comb begin
    state_n = state;
    sched_n = sched;
    init_n  = init_flag;
    case (state)
      IDLE: begin
        sched_n = '0;
        if (init_flag || in_gc_pkt_valid) state_n = JUDGE;
      end
      JUDGE: begin
        if (sched == '0) begin
          sched_n = elig;
        end else begin
          sched_n = '0;
          init_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign out_gc_schedule_valid = sched;

`ifdef GC_TOKEN_SHAPER_EN
  localparam int CNT_W = ($clog2(REFILL_CYC) > 7) ? $clog2(REFILL_CYC) : 7;

  logic [11:0]      rt, rt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             discard, discard_n;
  logic             wrap;
  logic             rd;
  logic             afford;
  logic [11:0]      consume;
  logic [13:0]      sum;
  logic             unused_bits;

  function automatic logic [11:0] sat_tb(input logic [13:0] v);
    if (v > 14'(TB_SIZE)) return 12'(TB_SIZE);
    else                  return v[11:0];
  endfunction

  // Refill and consumption merge into one update; consume never exceeds RT.
  always_comb begin
    wrap      = (cnt == CNT_W'(REFILL_CYC - 1));
    cnt_n     = wrap ? '0 : cnt + CNT_W'(1);
    rd        = in_gc_rden[SHAPE_Q];
    afford    = (rt >= {1'b0, in_gc_pkt_len});
    consume   = (rd && afford) ? {1'b0, in_gc_pkt_len} : 12'd0;
    discard_n = rd && !afford;
    sum       = {2'b00, rt} + {2'b00, in_gc_rate_limit[11:0]} - {2'b00, consume};
    rt_n      = wrap ? sat_tb(sum) : rt - consume;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt      <= '0;
      cnt     <= '0;
      discard <= 1'b0;
    end else begin
      rt      <= rt_n;
      cnt     <= cnt_n;
      discard <= discard_n;
    end
  end

  assign out_gc_bandwidth_discard = discard;
  assign unused_bits = ^{in_gc_rate_limit[31:12], in_gc_rden};
`else
  logic unused_shaper;

  assign out_gc_bandwidth_discard = 1'b0;
  assign unused_shaper = ^{in_gc_rate_limit, in_gc_pkt_len, in_gc_rden};
`endif

endmodule

// File: tb/tb_gate_ctrl_n.sv
// Self-checking bench for gate_ctrl_n: scheduling vectors, reset behaviour and token bucket.
module tb_gate_ctrl_n;

  localparam int QN = 4;
  localparam int PN = 2;
  localparam int PW = 2;
  localparam int UW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [QN*PW-1:0] md_outport;
  logic [QN-1:0]   fifo_empty;
  logic [QN-1:0]   gate_state;
  logic [10:0]     pkt_len;
  logic [31:0]     rate_limit;
  logic            pkt_valid;
  logic [PN*UW-1:0] usedw;
  logic [QN-1:0]   rden;
  logic [QN-1:0]   sched;
  logic            discard;

  gate_ctrl_n #(
    .QUEUE_NUM(QN), .PORT_NUM(PN), .PSEL_W(PW), .USEDW_W(UW),
    .USEDW_TH(20), .SHAPE_Q(2), .TB_SIZE(2047), .REFILL_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_gc_md_outport(md_outport), .in_gc_fifo_empty(fifo_empty),
    .in_gc_gate_state(gate_state), .in_gc_pkt_len(pkt_len),
    .in_gc_rate_limit(rate_limit), .in_gc_pkt_valid(pkt_valid),
    .pktout_usedw(usedw), .in_gc_rden(rden),
    .out_gc_schedule_valid(sched), .out_gc_bandwidth_discard(discard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gate;
    logic [3:0]  empty;
    logic [7:0]  op;
    logic [15:0] uw;
    logic [3:0]  exp;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         edge_n = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] got;
    logic [3:0] acc;
    logic [3:0] want;
    bit         seen;

    vecs[0] = '{4'hF, 4'hE, 8'h00, 16'h0005, 4'h1};
    vecs[1] = '{4'hF, 4'h0, 8'h00, 16'h0014, 4'hF};
    vecs[2] = '{4'h5, 4'h0, 8'h00, 16'h0014, 4'h5};
    vecs[3] = '{4'hF, 4'h0, 8'h44, 16'h0315, 4'hA};
    vecs[4] = '{4'hF, 4'h0, 8'h1E, 16'h0000, 4'hC};
    vecs[5] = '{4'hF, 4'h0, 8'hAA, 16'h0000, 4'h0};
    vecs[6] = '{4'h0, 4'h0, 8'h00, 16'h0000, 4'h0};
    vecs[7] = '{4'hF, 4'hF, 8'h00, 16'h0000, 4'h0};
    vecs[8] = '{4'h8, 4'h7, 8'h40, 16'h1400, 4'h8};
    vecs[9] = '{4'h8, 4'h7, 8'h40, 16'h1500, 4'h0};

    rst_n = 1'b0; pkt_valid = 1'b0; rden = '0; pkt_len = '0; rate_limit = '0;
    gate_state = 4'hF; fifo_empty = 4'hE; md_outport = '0; usedw = 16'h0005;
    #3;
    chk("rst_sched", 32'(sched), 32'h0);
    chk("rst_discard", 32'(discard), 32'h0);

    // First judgement after reset release, no packet-done needed
    @(negedge clk); rst_n = 1'b1; edge_n = 0;
    step(); chk("rel_e1", 32'(sched), 32'h0);
    step(); chk("rel_e2", 32'(sched), 32'h1);
    step(); chk("rel_e3", 32'(sched), 32'h0);
    acc = '0;
    repeat (3) begin step(); acc |= sched; end
    chk("idle_hold", 32'(acc), 32'h0);

    // Async reset while a result is showing, then re-judge from init_flag
    gate_state = 4'h3; fifo_empty = 4'h0;
    pkt_valid = 1'b1; step(); pkt_valid = 1'b0;
    step(); chk("pre_rst_res", 32'(sched), 32'h3);
    #1; rst_n = 1'b0; #1;
    chk("async_clr", 32'(sched), 32'h0);
    @(negedge clk); rst_n = 1'b1; edge_n = 0;
    step(); chk("rejudge_e1", 32'(sched), 32'h0);
    step(); chk("rejudge_e2", 32'(sched), 32'h3);
    step(); chk("rejudge_e3", 32'(sched), 32'h0);

    // Port fill-level ceiling boundary on queue 3 / port 1
    gate_state = 4'h8; fifo_empty = 4'h7; md_outport = 8'h40; usedw = {8'd21, 8'd0};
    pkt_valid = 1'b1; step(); pkt_valid = 1'b0;
    acc = '0;
    repeat (4) begin step(); acc |= sched; end
    chk("usedw21_blk", 32'(acc), 32'h0);
    usedw = {8'd20, 8'd0};
    step(); chk("usedw20_ok", 32'(sched), 32'h8);
    step(); chk("usedw20_clr", 32'(sched), 32'h0);

    // Table of eligibility patterns
    for (int i = 0; i < 10; i++) begin
      gate_state = vecs[i].gate; fifo_empty = vecs[i].empty;
      md_outport = vecs[i].op;   usedw      = vecs[i].uw;
      pkt_valid = 1'b1;
      exp_q.push_back(vecs[i].exp);
      step();
      pkt_valid = 1'b0;
      seen = 1'b0; got = '0;
      for (int k = 0; k < 5 && !seen; k++) begin
        if (sched != '0) begin seen = 1'b1; got = sched; end
        else step();
      end
      want = exp_q.pop_front();
      chk($sformatf("vec%0d", i), 32'(got), 32'(want));
      if (seen) begin
        step();
        chk($sformatf("vec%0d_clr", i), 32'(sched), 32'h0);
      end
    end

    gate_state = '0;
`ifdef GC_TOKEN_SHAPER_EN
    // Refill timing, exact consumption, discard pulse, other-queue reads
    rate_limit = 32'd100; rden = '0;
    do_reset();
    go_to(98); rden = 4'b0100; pkt_len = 11'd1;
    step(); chk("tb_early", 32'(discard), 32'h1);
    rden = '0;
    step(); chk("tb_disc_1cyc", 32'(discard), 32'h0);
    go_to(300); rden = 4'b0100; pkt_len = 11'd300;
    step(); chk("tb_300", 32'(discard), 32'h0);
    pkt_len = 11'd64;
    step(); chk("tb_empty", 32'(discard), 32'h1);
    rden = '0;
    step(); chk("tb_empty_clr", 32'(discard), 32'h0);
    rden = 4'b0010;
    step(); chk("tb_other_q", 32'(discard), 32'h0);
    rden = '0;
    go_to(499); rden = 4'b0100; pkt_len = 11'd50;
    step(); chk("tb_coinc", 32'(discard), 32'h0);
    pkt_len = 11'd150;
    step(); chk("tb_after_coinc", 32'(discard), 32'h0);
    pkt_len = 11'd1;
    step(); chk("tb_exact", 32'(discard), 32'h1);
    rden = '0;

    // Saturation at TB_SIZE with consumption on the wrap cycle
    rate_limit = 32'd2047;
    do_reset();
    go_to(299); rden = 4'b0100; pkt_len = 11'd100;
    step(); chk("tb_sat_wrap", 32'(discard), 32'h0);
    pkt_len = 11'd2047;
    step(); chk("tb_sat_full", 32'(discard), 32'h0);
    pkt_len = 11'd1;
    step(); chk("tb_sat_exact", 32'(discard), 32'h1);
    rden = '0;
    step(); chk("tb_sat_clr", 32'(discard), 32'h0);
`else
    // Without the shaper a large shaped read never discards
    rate_limit = 32'd0;
    do_reset();
    rden = 4'b0100; pkt_len = 11'd1500;
    step(); chk("noshape_d1", 32'(discard), 32'h0);
    step(); chk("noshape_d2", 32'(discard), 32'h0);
    rden = '0;
    step(); chk("noshape_d3", 32'(discard), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_ctrl_n.md
GATE_CTRL_N -- requirements
Module: gate_ctrl_n

Interface
REQ-001 SHALL have parameters:
- QUEUE_NUM, default 4: number of queues.
- PORT_NUM, default 2: number of output ports.
- PSEL_W, default 1: outport select width per queue.
- USEDW_W, default 8: width of each port fill level.
- USEDW_TH, default 20: port fill-level ceiling for scheduling.
- SHAPE_Q, default 2: index of the token-bucket-shaped queue.
- TB_SIZE, default 2047: bucket depth in tokens.
- REFILL_CYC, default 100: refill period in cycles.
REQ-002 SHALL have ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- in_gc_md_outport  in  QUEUE_NUM*PSEL_W  per-queue head-packet outport; queue q at bits [q*PSEL_W +: PSEL_W].
- in_gc_fifo_empty  in  QUEUE_NUM  per-queue empty flags.
- in_gc_gate_state  in  QUEUE_NUM  per-queue gate open (1) or closed (0) from LCM.
- in_gc_pkt_len  in  11  byte length of the packet being read from SHAPE_Q.
- in_gc_rate_limit  in  32  tokens added per refill period; only [11:0] are used.
- in_gc_pkt_valid  in  1  EBM packet-done pulse; re-arms judging.
- pktout_usedw  in  PORT_NUM*USEDW_W  per-port output FIFO fill levels.
- in_gc_rden  in  QUEUE_NUM  per-queue read strobes from TS.
- out_gc_schedule_valid  out  QUEUE_NUM  per-queue schedulable flags.
- out_gc_bandwidth_discard  out  1  discard pulse for a shaped packet.

Function
REQ-003 SHALL compute per-queue eligibility elig[q] = gate_state[q] & !fifo_empty[q] & (outport[q] < PORT_NUM) & (usedw[outport[q]] <= USEDW_TH); an out-of-range outport makes the queue ineligible.
REQ-004 SHALL run a two-state FSM:
- IDLE goes to JUDGE when init_flag or in_gc_pkt_valid is 1; otherwise it stays in IDLE.
- In JUDGE, when out_gc_schedule_valid == 0, it SHALL register elig into out_gc_schedule_valid every cycle and stay in JUDGE.
- In JUDGE, when out_gc_schedule_valid != 0, it SHALL clear out_gc_schedule_valid, clear init_flag and return to IDLE.
REQ-005 The result SHALL be a nonzero schedule vector held for exactly one cycle, appearing one cycle after elig first becomes nonzero in JUDGE. Multiple bits MAY be set; TS arbitrates.
REQ-006 in_gc_pkt_valid asserted in JUDGE SHALL be ignored (not queued).
REQ-007 The token bucket SHALL keep a 12-bit RT and a 7-bit-minimum refill counter, both updated on posedge clk only. The counter SHALL wrap from REFILL_CYC-1 to 0.
REQ-008 On in_gc_rden[SHAPE_Q] with RT >= {1'b0,pkt_len}, the block SHALL consume pkt_len tokens at that same edge and drive discard=0.
REQ-009 On in_gc_rden[SHAPE_Q] with RT < pkt_len, it SHALL consume nothing and drive out_gc_bandwidth_discard=1 for exactly one cycle, registered one cycle after rden.
REQ-010 On the refill-wrap cycle, RT SHALL become min(RT + rate[11:0] - consume, TB_SIZE), computed at 14-bit width. When refill and consume coincide, both SHALL apply in one update.
REQ-011 RT SHALL never underflow or exceed TB_SIZE.
REQ-012 rden on queues other than SHAPE_Q SHALL not affect RT or discard.

Reset
REQ-013 On rst_n=0, asynchronously: out_gc_schedule_valid=0, out_gc_bandwidth_discard=0, state=IDLE, init_flag=1, RT=0, refill counter=0.
REQ-014 Reset asserted mid-JUDGE or mid-refill SHALL abort immediately. After release the block SHALL re-judge without needing in_gc_pkt_valid.

Configuration
REQ-015 Macro GC_TOKEN_SHAPER_EN:
- When defined, the token bucket (REQ-007..012) is compiled in.
- When undefined, the bucket logic is absent, out_gc_bandwidth_discard is tied 0, and in_gc_rate_limit and in_gc_pkt_len are ignored.
- Scheduling behaviour is identical either way.

Verification
REQ-016 Reset release, gate=4'hF, empty=4'hE, outport0=0, usedw0=5 -> schedule_valid=4'h1 for one cycle at the 2nd cycle after release, then 0 and FSM in IDLE.
REQ-017 Queue 3 nonempty, gate[3]=1, outport3=1, usedw1=21 -> schedule_valid stays 0. Lowering usedw1 to 20 -> 4'h8 one cycle later.
REQ-018 rate=100, after 3 refill periods with no reads (RT=300), rden[2] with len=300 -> discard=0, RT=0. Next rden with len=64 before refill -> discard=1 for one cycle.
REQ-019 rate=2047 for 2 periods -> RT saturates at 2047. rden[2] len=100 on the wrap cycle -> RT=min(2047+2047-100, 2047)=2047.
REQ-020 Compile without GC_TOKEN_SHAPER_EN, rden[2] with len=1500 and RT nominally 0 -> discard stays 0. Schedule results match REQ-016/017.
